tile_mem_arbiter: RTL and testbench

TILE_MEM_ARBITER -- requirements
Module: tile_mem_arbiter

---
 rtl/tile_arb_pkg.sv | 12 +
 rtl/tile_wr_buf.sv | 54 +++++
 rtl/tile_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_tile_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_arb_pkg.sv
// Shared types and default widths for the tile RAM arbiter.
package tile_arb_pkg;
   localparam int ADDR_W_DEF     = 14;
   localparam int DATA_W_DEF     = 8;
   localparam int STARVE_MAX_DEF = 255;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_R    = 2'd1,
      TAG_G    = 2'd2
   } tag_e;
endpackage

// File: rtl/tile_wr_buf.sv
// Single-entry write buffer: ready while empty, cleared when the arbiter drains it.
module tile_wr_buf
   import tile_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              drain,
   output logic              full,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_data
);
   logic              full_q, full_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A draining entry keeps ready low, so a same-cycle offer waits one cycle.
   assign in_ready = ~full_q & ~Reset;

   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (drain) begin
         full_d = 1'b0;
      end else if (in_valid && in_ready) begin
         full_d = 1'b1;
         addr_d = in_addr;
         data_d = in_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full     = full_q;
   assign buf_addr = addr_q;
   assign buf_data = data_q;
endmodule

// File: rtl/tile_mem_arbiter.sv
// Tile RAM arbiter: renderer > starved game > buffered write > game on one single-port RAM.
// The write port exists only when TILE_ARB_WRITE_EN is defined.
module tile_mem_arbiter
   import tile_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] r_rdata,
   output logic              r_rvalid,
   input  logic              g_req,
   input  logic [ADDR_W-1:0] g_addr,
   output logic              g_gnt,
   output logic [DATA_W-1:0] g_rdata,
   output logic              g_rvalid,
   input  logic              w_valid,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_ready,
   input  logic              vblank,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic              grant_r, grant_g, grant_w;
   logic              write_cand, g_starved;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   tag_e              tag_q, tag_d;
   logic              r_rvalid_q, r_rvalid_d, g_rvalid_q, g_rvalid_d;
   logic [DATA_W-1:0] r_rdata_q, r_rdata_d, g_rdata_q, g_rdata_d;

`ifdef TILE_ARB_WRITE_EN
   logic wb_full;

   tile_wr_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_buf (
      .Clk      (Clk),
      .Reset    (Reset),
      .in_valid (w_valid),
      .in_addr  (w_addr),
      .in_data  (w_data),
      .in_ready (w_ready),
      .drain    (grant_w),
      .full     (wb_full),
      .buf_addr (wb_addr),
      .buf_data (wb_data)
   );

   assign write_cand = wb_full & vblank;
`else
   logic unused_w;

   assign unused_w   = ^{w_valid, w_addr, w_data, vblank};
   assign w_ready    = 1'b0;
   assign write_cand = 1'b0;
   assign wb_addr    = '0;
   assign wb_data    = '0;
`endif

   assign g_starved = (starve_cnt_q >= STARVE_LIM);

   // A starved game request only outranks the write; the renderer always wins.
   always_comb begin
      grant_r = 1'b0;
      grant_g = 1'b0;
      grant_w = 1'b0;
      if (!Reset) begin
         if (r_req)                              grant_r = 1'b1;
         else if (write_cand && !(g_req && g_starved)) grant_w = 1'b1;
         else if (g_req)                         grant_g = 1'b1;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      tag_d     = TAG_NONE;
      if (grant_r) begin
         mem_addr = r_addr;
         tag_d    = TAG_R;
      end else if (grant_g) begin
         mem_addr = g_addr;
         tag_d    = TAG_G;
      end else if (grant_w) begin
         mem_addr  = wb_addr;
         mem_wdata = wb_data;
      end
   end

   assign mem_we = grant_w;
   assign g_gnt  = grant_g;

   always_comb begin
      r_rvalid_d   = (tag_q == TAG_R);
      g_rvalid_d   = (tag_q == TAG_G);
      r_rdata_d    = r_rvalid_d ? mem_rdata : r_rdata_q;
      g_rdata_d    = g_rvalid_d ? mem_rdata : g_rdata_q;
      starve_cnt_d = starve_cnt_q;
      if (grant_g)
         starve_cnt_d = '0;
      else if (g_req && (starve_cnt_q < STARVE_LIM))
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         tag_q        <= TAG_NONE;
         r_rvalid_q   <= 1'b0;
         g_rvalid_q   <= 1'b0;
         r_rdata_q    <= '0;
         g_rdata_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         tag_q        <= tag_d;
         r_rvalid_q   <= r_rvalid_d;
         g_rvalid_q   <= g_rvalid_d;
         r_rdata_q    <= r_rdata_d;
         g_rdata_q    <= g_rdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Returns read as idle for the whole reset interval, including its first cycle.
   assign r_rvalid = r_rvalid_q & ~Reset;
   assign g_rvalid = g_rvalid_q & ~Reset;
   assign r_rdata  = Reset ? '0 : r_rdata_q;
   assign g_rdata  = Reset ? '0 : g_rdata_q;
endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Randomized bench for tile_mem_arbiter with a cycle-level reference model and RAM model.
// Expectations follow TILE_ARB_WRITE_EN the same way the design does.
module tb_tile_mem_arbiter;
   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 8;
   localparam int STARVE_MAX = 255;
`ifdef TILE_ARB_WRITE_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              Reset, r_req, g_req, w_valid, vblank;
   logic [ADDR_W-1:0] r_addr, g_addr, w_addr;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W-1:0] r_rdata, g_rdata, mem_wdata, mem_rdata;
   logic              r_rvalid, g_gnt, g_rvalid, w_ready, mem_we;
   logic [ADDR_W-1:0] mem_addr;

   always #5 Clk = ~Clk;

   tile_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .Clk(Clk), .Reset(Reset),
      .r_req(r_req), .r_addr(r_addr), .r_rdata(r_rdata), .r_rvalid(r_rvalid),
      .g_req(g_req), .g_addr(g_addr), .g_gnt(g_gnt), .g_rdata(g_rdata), .g_rvalid(g_rvalid),
      .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
      .vblank(vblank),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // RAM with registered read; untouched words hold an address-derived pattern.
   function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
      return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h3C;
   endfunction

   logic [DATA_W-1:0] ram    [2**ADDR_W];
   bit                ram_wr [2**ADDR_W];
   always @(posedge Clk) begin
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      if (mem_we) begin
         ram[mem_addr]    <= mem_wdata;
         ram_wr[mem_addr] <= 1'b1;
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [int];
   bit                exp_rv [8];
   bit                exp_gv [8];
   logic [DATA_W-1:0] exp_rd [8];
   logic [DATA_W-1:0] exp_gd [8];
   logic [DATA_W-1:0] hold_r = '0, hold_g = '0;
   bit                m_wb_full = 1'b0;
   logic [ADDR_W-1:0] m_wb_addr = '0;
   logic [DATA_W-1:0] m_wb_data = '0;
   int                gwait = 0;
   int                cyc = 0;
   int                n_tests = 0, n_fail = 0;
   int                n_writes = 0, n_rreads = 0, n_greads = 0;

   task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_rd(logic [ADDR_W-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   // One clock cycle: check this cycle's outputs, advance the model, release accepted requests.
   task automatic step();
      int                t0, t1, t2, kind;
      bit                exp_wr, acc;
      logic [ADDR_W-1:0] ea;
      t0 = cyc % 8; t1 = (cyc + 1) % 8; t2 = (cyc + 2) % 8;
      acc = 1'b0;
      #1;
      if (Reset) begin
         exp_rv[t0] = 1'b0; exp_rv[t1] = 1'b0;
         exp_gv[t0] = 1'b0; exp_gv[t1] = 1'b0;
         hold_r = '0; hold_g = '0;
      end
      if (exp_rv[t0]) hold_r = exp_rd[t0];
      if (exp_gv[t0]) hold_g = exp_gd[t0];
      check("r_rvalid", 32'(r_rvalid), 32'(exp_rv[t0]));
      check("r_rdata",  32'(r_rdata),  32'(hold_r));
      check("g_rvalid", 32'(g_rvalid), 32'(exp_gv[t0]));
      check("g_rdata",  32'(g_rdata),  32'(hold_g));
      exp_rv[t0] = 1'b0; exp_gv[t0] = 1'b0;

      // 0 idle, 1 renderer, 2 game, 3 write
      kind = 0;
      if (!Reset) begin
         if (r_req)                                        kind = 1;
         else if (WEN && g_req && gwait >= STARVE_MAX)     kind = 2;
         else if (WEN && m_wb_full && vblank)              kind = 3;
         else if (g_req)                                   kind = 2;
      end
      ea = (kind == 1) ? r_addr : (kind == 2) ? g_addr : (kind == 3) ? m_wb_addr : '0;
      check("mem_addr", 32'(mem_addr), 32'(ea));
      check("mem_we",   32'(mem_we),   32'(kind == 3));
      check("g_gnt",    32'(g_gnt),    32'(kind == 2));
      if (kind == 3) check("mem_wdata", 32'(mem_wdata), 32'(m_wb_data));
      exp_wr = WEN && !Reset && !m_wb_full;
      check("w_ready", 32'(w_ready), 32'(exp_wr));

      if (Reset) begin
         m_wb_full = 1'b0;
         gwait     = 0;
      end else begin
         case (kind)
            1: begin exp_rv[t2] = 1'b1; exp_rd[t2] = ref_rd(r_addr); n_rreads++; end
            2: begin exp_gv[t2] = 1'b1; exp_gd[t2] = ref_rd(g_addr); n_greads++; end
            3: begin ref_mem[int'(m_wb_addr)] = m_wb_data; m_wb_full = 1'b0; n_writes++; end
            default: ;
         endcase
         if (kind == 2)  gwait = 0;
         else if (g_req) gwait++;
         if (exp_wr && w_valid) begin
            m_wb_full = 1'b1; m_wb_addr = w_addr; m_wb_data = w_data; acc = 1'b1;
         end
      end
      @(negedge Clk); #1;
      if (kind == 2) g_req = 1'b0;
      if (acc)       w_valid = 1'b0;
      cyc++;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Keep stepping until the pending game request is granted, within a bound.
   task automatic wait_g(int bound);
      for (int i = 0; i < bound && g_req; i++) step();
      check("g_req_granted", 32'(g_req), 32'(0));
   endtask

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom);
      return ADDR_W'($urandom_range(0, 15));
   endfunction

   initial begin
      Reset = 1'b1; r_req = 1'b0; g_req = 1'b0; w_valid = 1'b0; vblank = 1'b0;
      r_addr = '0; g_addr = '0; w_addr = '0; w_data = '0;
      @(negedge Clk); #1;
      steps(3);
      Reset = 1'b0;
      steps(2);

      $display("[TB] scenario: renderer and game request together");
      r_req = 1'b1; r_addr = 14'h010; g_req = 1'b1; g_addr = 14'h020;
      step();
      r_req = 1'b0;
      wait_g(4);
      steps(3);

      $display("[TB] scenario: write buffered outside vblank, issued in vblank");
      w_valid = 1'b1; w_addr = 14'h100; w_data = 8'h5A; vblank = 1'b0;
      steps(5);
      vblank = 1'b1;
      steps(3);
      vblank = 1'b0;
      g_req = 1'b1; g_addr = 14'h100;
      wait_g(4);
      steps(3);

      $display("[TB] scenario: game starved behind 300 renderer cycles with write pending");
      w_valid = 1'b1; w_addr = 14'h101; w_data = 8'hC3; vblank = 1'b1;
      r_req = 1'b1; r_addr = 14'h030; g_req = 1'b1; g_addr = 14'h101;
      steps(300);
      r_req = 1'b0;
      steps(4);

      for (int k = 254; k <= 256; k++) begin
         $display("[TB] scenario: game waits %0d cycles against pending write", k);
         vblank = 1'b0; w_valid = 1'b1; w_addr = 14'h102; w_data = 8'(k);
         step();
         vblank = 1'b1; r_req = 1'b1; r_addr = 14'h003; g_req = 1'b1; g_addr = 14'h102;
         steps(k);
         r_req = 1'b0;
         steps(4);
      end

      $display("[TB] scenario: reset one cycle after renderer request");
      vblank = 1'b0; w_valid = 1'b1; w_addr = 14'h005; w_data = 8'h77;
      step();
      r_req = 1'b1; r_addr = 14'h006;
      step();
      r_req = 1'b0; Reset = 1'b1;
      step();
      Reset = 1'b0; vblank = 1'b1;
      steps(4);

      $display("[TB] scenario: randomized traffic");
      for (int seg = 0; seg < 24; seg++) begin
         int r_pct, vb_mode, len;
         r_pct   = (seg % 4 == 3) ? 100 : $urandom_range(0, 80);
         vb_mode = $urandom_range(0, 2);
         len     = (r_pct == 100) ? $urandom_range(200, 300) : $urandom_range(60, 160);
         for (int i = 0; i < len; i++) begin
            Reset  = ($urandom_range(0, 299) == 0);
            r_req  = ($urandom_range(0, 99) < r_pct);
            r_addr = rnd_addr();
            if (!g_req && $urandom_range(0, 2) == 0) begin
               g_req = 1'b1; g_addr = rnd_addr();
            end
            if (!w_valid && $urandom_range(0, 3) == 0) begin
               w_valid = 1'b1; w_addr = rnd_addr(); w_data = DATA_W'($urandom);
            end
            vblank = (vb_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(vb_mode);
            step();
         end
      end
      Reset = 1'b0; r_req = 1'b0; vblank = 1'b1;
      steps(8);

      $display("[TB] traffic: %0d renderer reads, %0d game reads, %0d writes", n_rreads, n_greads, n_writes);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
